// File: rtl/seg_mux_scheduler.sv
// Dual-digit display scheduler: two-key history, dead-time blanked digit slots.
// Optional SEG_LEADING_BLANK_EN keeps the left digit dark until two keys arrive.
module seg_mux_scheduler #(
    parameter int REFRESH_DIV      = 50000,
    parameter int DEADTIME         = 100,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_key,
    input  logic [3:0] digit,
    output logic [3:0] seg_digit,
    output logic [1:0] anode,
    output logic [3:0] new_digit,
    output logic [3:0] old_digit,
    output logic       frame_done
);

    localparam int MAXLEN = (REFRESH_DIV > DEADTIME) ? REFRESH_DIV : DEADTIME;
    localparam int CW     = $clog2(MAXLEN);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(DEADTIME - 1);

    localparam logic [1:0] AN_OFF = (ANODE_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic [1:0] AN_R   = (ANODE_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;
    localparam logic [1:0] AN_L   = (ANODE_ACTIVE_LOW != 0) ? 2'b01 : 2'b10;

    typedef enum logic [1:0] {
        BLANK_R,
        SHOW_R,
        BLANK_L,
        SHOW_L
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;
    logic [1:0]    w_anode_nxt;
    logic          w_frame_nxt;
    logic          w_load_r;
    logic          w_load_l;
    logic          w_left_en;

`ifdef SEG_LEADING_BLANK_EN
    logic [1:0] r_key_cnt;
    logic [1:0] w_key_nxt;

    always_comb begin
        w_key_nxt = r_key_cnt;
        if (valid_key && r_key_cnt != 2'd2) begin
            w_key_nxt = r_key_cnt + 2'd1;
        end
    end

    // Left digit lights only once a genuine previous key exists.
    assign w_left_en = w_key_nxt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_cnt <= 2'd0;
        end else begin
            r_key_cnt <= w_key_nxt;
        end
    end
`else
    assign w_left_en = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_last      = 1'b0;
        w_load_r    = 1'b0;
        w_load_l    = 1'b0;
        unique case (r_state)
            BLANK_R: begin
                w_last   = (r_cnt == BLANK_LAST);
                w_load_r = w_last;
                if (w_last) w_state_nxt = SHOW_R;
            end
            SHOW_R: begin
                w_last = (r_cnt == SHOW_LAST);
                if (w_last) w_state_nxt = BLANK_L;
            end
            BLANK_L: begin
                w_last   = (r_cnt == BLANK_LAST);
                w_load_l = w_last;
                if (w_last) w_state_nxt = SHOW_L;
            end
            SHOW_L: begin
                w_last = (r_cnt == SHOW_LAST);
                if (w_last) w_state_nxt = BLANK_R;
            end
            default: begin
                w_state_nxt = BLANK_R;
            end
        endcase
        if (w_last) w_cnt_nxt = '0;

        // Outputs are computed from the next state so they align with it.
        w_anode_nxt = AN_OFF;
        w_frame_nxt = 1'b0;
        unique case (w_state_nxt)
            SHOW_R: w_anode_nxt = AN_R;
            SHOW_L: begin
                if (w_left_en) w_anode_nxt = AN_L;
                w_frame_nxt = (w_cnt_nxt == SHOW_LAST);
            end
            default: w_anode_nxt = AN_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BLANK_R;
            r_cnt      <= '0;
            new_digit  <= 4'd0;
            old_digit  <= 4'd0;
            seg_digit  <= 4'd0;
            anode      <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            anode      <= w_anode_nxt;
            frame_done <= w_frame_nxt;
            if (valid_key) begin
                old_digit <= new_digit;
                new_digit <= digit;
            end
            if (w_load_r) seg_digit <= new_digit;
            if (w_load_l) seg_digit <= old_digit;
        end
    end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Scoreboard bench for seg_mux_scheduler (REFRESH_DIV=4, DEADTIME=2).
// Expected frame pattern comes from a hand-written 12-entry slot table.
module tb_seg_mux_scheduler;

    typedef struct {
        logic [1:0] an;
        logic [3:0] seg;
        logic [3:0] nw;
        logic [3:0] od;
        logic       fd;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_key = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [3:0] seg_digit;
    logic [1:0] anode;
    logic [3:0] new_digit;
    logic [3:0] old_digit;
    logic       frame_done;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int step_no = 0;

    int pos = 0;
    int keys = 0;
    logic [3:0] m_new = 4'd0;
    logic [3:0] m_old = 4'd0;
    logic [3:0] m_seg = 4'd0;

    always #5 clk = ~clk;

    seg_mux_scheduler #(
        .REFRESH_DIV(4),
        .DEADTIME(2),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_key(valid_key),
        .digit(digit),
        .seg_digit(seg_digit),
        .anode(anode),
        .new_digit(new_digit),
        .old_digit(old_digit),
        .frame_done(frame_done)
    );

    function automatic logic [1:0] an_at(input int p, input int k);
        logic [1:0] a;
        if (p < 2) a = 2'b11;
        else if (p < 6) a = 2'b10;
        else if (p < 8) a = 2'b11;
        else a = 2'b01;
`ifdef SEG_LEADING_BLANK_EN
        if (p >= 8 && k < 2) a = 2'b11;
`endif
        return a;
    endfunction

    // One clock: drive inputs, push expected outputs after the coming edge.
    task automatic step(input logic vk, input logic [3:0] d, input logic rst);
        exp_t e;
        @(negedge clk);
        valid_key = vk;
        digit     = d;
        reset     = rst;
        if (rst) begin
            pos = 0;
            keys = 0;
            m_new = 4'd0;
            m_old = 4'd0;
            m_seg = 4'd0;
        end else begin
            pos = (pos + 1) % 12;
            if (pos == 2) m_seg = m_new;
            if (pos == 8) m_seg = m_old;
            if (vk) begin
                m_old = m_new;
                m_new = d;
                if (keys < 2) keys++;
            end
        end
        e.an  = rst ? 2'b11 : an_at(pos, keys);
        e.seg = m_seg;
        e.nw  = m_new;
        e.od  = m_old;
        e.fd  = (!rst && pos == 11);
        e.idx = step_no;
        step_no++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
    endtask

    // Advance until the DUT sits at frame position p.
    task automatic run_to(input int p);
        for (int i = 0; i < 12 && pos != p; i++) step(1'b0, 4'd0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (anode !== e.an || seg_digit !== e.seg ||
                    new_digit !== e.nw || old_digit !== e.od ||
                    frame_done !== e.fd) begin
                    bad++;
                    $display("FAIL step%0d: got an=%b seg=%0d new=%0d old=%0d fd=%b want an=%b seg=%0d new=%0d old=%0d fd=%b",
                             e.idx, anode, seg_digit, new_digit, old_digit,
                             frame_done, e.an, e.seg, e.nw, e.od, e.fd);
                end
            end
        end
    end

    initial begin : stim
        // reset hold
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd8, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        // two frames, no keys
        idle(24);
        // keys 5 then 9, then a full frame showing them
        step(1'b1, 4'd5, 1'b0);
        idle(3);
        step(1'b1, 4'd9, 1'b0);
        run_to(0);
        idle(12);
        // key 3 during 2nd cycle of SHOW_R
        run_to(3);
        step(1'b1, 4'd3, 1'b0);
        run_to(0);
        idle(12);
        // key coincident with entry to SHOW_R
        run_to(1);
        step(1'b1, 4'd4, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        run_to(0);
        idle(12);
        // reset in 3rd cycle of SHOW_L with a key on the same cycle
        run_to(10);
        step(1'b1, 4'd1, 1'b1);
        idle(13);
        // leading-blank scenario: one key, then a second
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd7, 1'b0);
        run_to(0);
        idle(12);
        step(1'b1, 4'd2, 1'b0);
        run_to(0);
        idle(12);
        @(negedge clk);
        valid_key = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_mux_scheduler.md
Name: seg_mux_scheduler

Overview:
- Time-multiplexes the single shared seven-segment decoder between the two digits of the dual display.
- Keeps a two-digit history fed by the keypad FSM's valid_key/digit outputs: right digit = newest key, left digit = previous key.
- Inserts dead-time blanking between digit slots to prevent ghosting.
- Sits between keypad_fsm and the seven-segment decoder/anode drivers.

Parameters:
- REFRESH_DIV, 50000: clock cycles per SHOW slot; must be >= 2.
- DEADTIME, 100: clock cycles per BLANK slot, both anodes off; must be >= 1.
- ANODE_ACTIVE_LOW, 1: 1 means an anode is on when driven 0; 0 means on when driven 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid_key  in  1  single-cycle strobe from the keypad FSM: new key accepted
- digit  in  4  key value; sampled when valid_key=1
- seg_digit  out  4  value presented to the shared seven-segment decoder
- anode  out  2  anode enables; bit0 = right digit, bit1 = left digit
- new_digit  out  4  most recent key (history register)
- old_digit  out  4  previous key (history register)
- frame_done  out  1  one-cycle pulse on the last cycle of SHOW_L

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on port reset, sampled on the rising edge of clk.
- Reset values:
  - state=BLANK_R, slot counter=0.
  - new_digit=0, old_digit=0, seg_digit=0, frame_done=0.
  - anode = both off: 2'b11 if ANODE_ACTIVE_LOW, else 2'b00.
- History:
  - On any clock edge with valid_key=1 and reset=0: old_digit <= new_digit, new_digit <= digit.
  - Visible one cycle after the strobe.
  - Every cycle valid_key is high causes one shift; there is no edge detection.
- State machine: BLANK_R -> SHOW_R -> BLANK_L -> SHOW_L -> BLANK_R, repeating forever.
  - BLANK states last DEADTIME cycles; SHOW states last REFRESH_DIV cycles.
  - The counter clears on every transition. A state exits on the edge where counter == length-1.
  - Frame period = 2*(DEADTIME+REFRESH_DIV) cycles.
- Outputs (all registered, aligned with the state they describe):
  - BLANK_x: both anodes off.
  - SHOW_R: right anode on only. SHOW_L: left anode on only.
  - frame_done=1 only during the final cycle of SHOW_L.
- Display latching:
  - seg_digit is loaded on the edge entering SHOW_R (from new_digit) or SHOW_L (from old_digit).
  - It holds for the whole slot and through the following BLANK.
  - History changes mid-slot appear at that digit's next SHOW slot; there is no tearing within a slot.
- Simultaneous events:
  - valid_key on the same edge as entry to SHOW_x: seg_digit latches the pre-update register value.
- Reset mid-operation:
  - On the next edge, all state and outputs return to their reset values from any state and any counter value.
  - A valid_key in the same cycle as reset is ignored.
- Counter width: $clog2(max(REFRESH_DIV, DEADTIME)) bits, with no overflow or wrap beyond length-1.

Optional Feature:
- Macro: SEG_LEADING_BLANK_EN.
- Defined:
  - A saturating 2-bit key counter (0..2) increments on each valid_key and is cleared by reset.
  - While the counter < 2, the left anode stays off during SHOW_L, so only BLANK-level output appears on the left digit.
  - Timing, frame_done and seg_digit loading are unchanged.
- Undefined:
  - No key counter. The left digit shows old_digit, initially 0, from the first frame.

Test Plan (REFRESH_DIV=4, DEADTIME=2, ANODE_ACTIVE_LOW=1):
1. Reset held 3 cycles -> anode=2'b11, seg_digit=0, new_digit=old_digit=0, frame_done=0 on every cycle during reset.
2. Release reset, no keys; cycle 0 = first cycle after release -> expected sequence:
   - cycles 0-1: anode=11
   - cycles 2-5: anode=10
   - cycles 6-7: anode=11
   - cycles 8-11: anode=01, with frame_done=1 only at cycle 11
   - cycle 12: repeats from cycle 0
3. One-cycle valid_key with digit=5, later another with digit=9 -> after the first, new=5/old=0; after the second, new=9/old=5. Next frame: seg_digit=9 during SHOW_R and 5 during SHOW_L.
4. valid_key with digit=3 in the 2nd cycle of SHOW_R (new was 9) -> seg_digit stays 9 to the end of that slot; it becomes 3 at the following SHOW_R.
5. Reset asserted in the 3rd cycle of SHOW_L with new=3, old=9 -> next edge: anode=11, seg_digit=0, history=0, state BLANK_R. After release, the sequence restarts exactly as in test 2.
6. SEG_LEADING_BLANK_EN defined, one key (digit=7) -> SHOW_L keeps anode=11 while SHOW_R shows 7. After a second key (digit=2), the next SHOW_L drives anode=01 with seg_digit=7. Without the macro, the left digit shows 0 after the first key.
